// File: rtl/pow_job_sequencer.sv
// Job FIFO and issue/ack sequencer in front of the iterative power unit (A^B).
// Optional trivial-exponent short-circuit enabled by defining POWSEQ_BYPASS_EN.
module pow_job_sequencer #(
    parameter int DEPTH = 4,
    parameter int AW    = 2,
    parameter int TAGW  = 8
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_a,
    input  logic [31:0]     in_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [63:0]     out_r,
    output logic [TAGW-1:0] out_tag,
    output logic [31:0]     pow_a,
    output logic [31:0]     pow_b,
    output logic            pow_start,
    input  logic [63:0]     pow_r,
    input  logic            pow_ack
);

    // state | meaning
    // IDLE  | waiting for a queued job and a free result buffer
    // ISSUE | pow_start pulse to the power unit
    // CLR   | waiting for the previous job's ack to drop
    // WAIT  | waiting for the unit's ack; capture R on it
    // DONE  | publish result and tag, advance tag counter
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        CLR   = 3'd2,
        WAIT  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic [31:0]     fifo_a [DEPTH];
    logic [31:0]     fifo_b [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;
    logic [31:0]     head_a;
    logic [31:0]     head_b;
    logic [TAGW-1:0] tag_cnt;
    logic            load_job;
    logic            cap_r;
    logic            cap_byp;
    logic            set_valid;
    logic            byp_hit;
    logic [63:0]     byp_r;

    // Full blocks a push even when a pop happens in the same cycle.
    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign in_ready = !Rst && !full;
    assign push     = in_valid && in_ready;
    assign head_a   = fifo_a[rd_ptr];
    assign head_b   = fifo_b[rd_ptr];

    always_ff @(posedge Clk) begin
        if (push) begin
            fifo_a[wr_ptr] <= in_a;
            fifo_b[wr_ptr] <= in_b;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef POWSEQ_BYPASS_EN
    always_comb begin
        byp_hit = 1'b1;
        byp_r   = '0;
        if (head_b == 32'd0) begin
            byp_r = 64'd1;
        end else if (head_b == 32'd1) begin
            byp_r = {32'd0, head_a};
        end else if (head_a == 32'd0) begin
            byp_r = 64'd0;
        end else if (head_a == 32'd1) begin
            byp_r = 64'd1;
        end else begin
            byp_hit = 1'b0;
        end
    end
`else
    assign byp_hit = 1'b0;
    assign byp_r   = '0;
`endif

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        load_job  = 1'b0;
        cap_r     = 1'b0;
        cap_byp   = 1'b0;
        set_valid = 1'b0;
        pow_start = 1'b0;
        case (state)
            IDLE: begin
                // A single result buffer: hold off until the previous result is taken.
                if (!empty && !out_valid) begin
                    pop = 1'b1;
                    if (byp_hit) begin
                        cap_byp   = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        load_job  = 1'b1;
                        state_nxt = ISSUE;
                    end
                end
            end
            ISSUE: begin
                pow_start = !Rst;
                state_nxt = CLR;
            end
            CLR: begin
                if (!pow_ack) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (pow_ack) begin
                    cap_r     = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                set_valid = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            pow_a     <= '0;
            pow_b     <= '0;
            out_r     <= '0;
            out_tag   <= '0;
            out_valid <= 1'b0;
            tag_cnt   <= '0;
        end else begin
            if (load_job) begin
                pow_a <= head_a;
                pow_b <= head_b;
            end
            // out_valid is always low here, so out_r never changes under a held result.
            if (cap_r) begin
                out_r <= pow_r;
            end else if (cap_byp) begin
                out_r <= byp_r;
            end
            if (set_valid) begin
                out_valid <= 1'b1;
                out_tag   <= tag_cnt;
                tag_cnt   <= tag_cnt + 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pow_job_sequencer.sv
// Directed bench for pow_job_sequencer with a behavioural power-unit model.
// Build with POWSEQ_BYPASS_EN defined to exercise the trivial-exponent path.
`timescale 1ns/1ps
module tb_pow_job_sequencer;

    localparam int TAGW = 8;

    logic            Clk = 1'b0;
    logic            Rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [31:0]     in_a = '0;
    logic [31:0]     in_b = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [63:0]     out_r;
    logic [TAGW-1:0] out_tag;
    logic [31:0]     pow_a;
    logic [31:0]     pow_b;
    logic            pow_start;
    logic [63:0]     pow_r = '0;
    logic            pow_ack = 1'b0;

    pow_job_sequencer #(.DEPTH(4), .AW(2), .TAGW(TAGW)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_r     (out_r),
        .out_tag   (out_tag),
        .pow_a     (pow_a),
        .pow_b     (pow_b),
        .pow_start (pow_start),
        .pow_r     (pow_r),
        .pow_ack   (pow_ack)
    );

    always #5 Clk = ~Clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int push_cyc = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_pow(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < int'(b); i++) r = r * {32'd0, a};
        return r;
    endfunction

    // Power unit: ack can stay stale for stale_cfg cycles after start, then
    // drops for lat_cfg cycles with junk on R, then rises with the result.
    int          stale_cfg = 0;
    int          lat_cfg   = 2;
    int          m_stale   = 0;
    int          m_cnt     = 0;
    logic        m_busy    = 1'b0;
    logic [31:0] ma        = '0;
    logic [31:0] mb        = '0;
    int          start_cnt = 0;
    int          start_cyc = 0;
    int          ack_cyc   = 0;

    always @(negedge Clk) begin
        if (pow_start) begin
            ma        <= pow_a;
            mb        <= pow_b;
            m_stale   <= stale_cfg;
            m_cnt     <= lat_cfg;
            m_busy    <= 1'b1;
            start_cnt <= start_cnt + 1;
            start_cyc <= cyc;
        end else if (m_busy) begin
            if (m_stale > 0) begin
                m_stale <= m_stale - 1;
            end else if (m_cnt > 0) begin
                pow_ack <= 1'b0;
                pow_r   <= 64'hA5A5_5A5A_DEAD_BEEF;
                m_cnt   <= m_cnt - 1;
            end else begin
                pow_ack <= 1'b1;
                pow_r   <= ref_pow(ma, mb);
                m_busy  <= 1'b0;
                ack_cyc <= cyc;
            end
        end
    end

    logic [63:0] res_r [$];
    logic [7:0]  res_t [$];
    logic        prev_valid = 1'b0;
    int          vrise_cyc  = 0;
    int          rd         = 0;

    always @(negedge Clk) begin
        if (!Rst && out_valid && !prev_valid) vrise_cyc <= cyc;
        prev_valid <= out_valid && !Rst;
        if (!Rst && out_valid && out_ready) begin
            res_r.push_back(out_r);
            res_t.push_back(out_tag);
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b);
        int n;
        n = 0;
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        while (!in_ready && n < 300) begin
            step();
            n++;
        end
        if (!in_ready) chk("push_stall", 64'(in_ready), 64'd1);
        step();
        push_cyc = cyc;
        in_valid = 1'b0;
    endtask

    task automatic expect_res(input string name, input logic [63:0] r, input logic [7:0] t);
        int n;
        n = 0;
        while (res_r.size() <= rd && n < 500) begin
            step();
            n++;
        end
        if (res_r.size() <= rd) begin
            chk({name, "_timeout"}, 64'(res_r.size()), 64'(rd + 1));
            return;
        end
        chk({name, "_r"}, res_r[rd], r);
        chk({name, "_tag"}, 64'(res_t[rd]), 64'(t));
        rd++;
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!out_valid && n < 500) begin
            step();
            n++;
        end
        if (!out_valid) chk({name, "_timeout"}, 64'(out_valid), 64'd1);
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        in_valid = 1'b0;
        step();
        step();
        Rst = 1'b0;
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    int base;
    int hi_cnt;
    int res_base;

    initial begin
        // Reset values
        Rst = 1'b1;
        step();
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_r", out_r, 64'd0);
        chk("rst_out_tag", 64'(out_tag), 64'd0);
        chk("rst_pow_start", 64'(pow_start), 64'd0);
        chk("rst_pow_a", 64'(pow_a), 64'd0);
        chk("rst_pow_b", 64'(pow_b), 64'd0);
        step();
        Rst = 1'b0;
        #1;
        chk("rel_in_ready", 64'(in_ready), 64'd1);

        // Single job 2^8
        out_ready = 1'b1;
        lat_cfg = 3;
        base = start_cnt;
        push(32'd2, 32'd8);
        expect_res("single", 64'd256, 8'd0);
        chk("single_starts", 64'(start_cnt - base), 64'd1);
        chk("single_push_to_start", 64'(start_cyc - push_cyc), 64'd1);
        chk("single_ack_to_valid", 64'(vrise_cyc - ack_cyc), 64'd2);
        chk("single_pow_a", 64'(pow_a), 64'd2);
        chk("single_pow_b", 64'(pow_b), 64'd8);

        // Four back-to-back jobs
        do_reset();
        lat_cfg = 2;
        base = start_cnt;
        push(32'd2, 32'd3);
        push(32'd3, 32'd4);
        push(32'd5, 32'd2);
        push(32'd7, 32'd2);
        expect_res("burst0", 64'd8, 8'd0);
        expect_res("burst1", 64'd81, 8'd1);
        expect_res("burst2", 64'd25, 8'd2);
        expect_res("burst3", 64'd49, 8'd3);
        chk("burst_starts", 64'(start_cnt - base), 64'd4);

        // Backpressure: result held, FIFO fills, nothing else issued
        out_ready = 1'b0;
        push(32'd3, 32'd3);
        wait_valid("hold");
        chk("hold_r", out_r, 64'd27);
        chk("hold_tag", 64'(out_tag), 64'd4);
        base = start_cnt;
        push(32'd2, 32'd10);
        push(32'd10, 32'd3);
        push(32'd2, 32'd64);
        push(32'd3, 32'd40);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        in_a = 32'd99;
        in_b = 32'd2;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) step();
        in_valid = 1'b0;
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_r_stable", out_r, 64'd27);
        chk("hold_tag_stable", 64'(out_tag), 64'd4);
        chk("hold_no_start", 64'(start_cnt - base), 64'd0);
        out_ready = 1'b1;
        expect_res("drain0", 64'd27, 8'd4);
        expect_res("drain1", 64'd1024, 8'd5);
        expect_res("drain2", 64'd1000, 8'd6);
        expect_res("drain3_wrap64", 64'd0, 8'd7);
        expect_res("drain4", 64'd12157665459056928801, 8'd8);
        for (int i = 0; i < 20; i++) step();
        chk("drain_no_extra", 64'(res_r.size()), 64'(rd));

        // Stale ack held high after start: no capture until it drops and rises
        stale_cfg = 6;
        push(32'd5, 32'd3);
        hi_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (out_valid) hi_cnt++;
        end
        chk("stale_no_early_valid", 64'(hi_cnt), 64'd0);
        expect_res("stale", 64'd125, 8'd9);
        stale_cfg = 0;

        // Trivial exponents
        base = start_cnt;
        push(32'd9, 32'd0);
        expect_res("triv_b0", 64'd1, 8'd10);
`ifdef POWSEQ_BYPASS_EN
        chk("byp_pop_to_valid", 64'(vrise_cyc - push_cyc), 64'd2);
`endif
        push(32'd9, 32'd1);
        expect_res("triv_b1", 64'd9, 8'd11);
        push(32'd0, 32'd5);
        expect_res("triv_a0", 64'd0, 8'd12);
        push(32'd1, 32'd7);
        expect_res("triv_a1", 64'd1, 8'd13);
`ifdef POWSEQ_BYPASS_EN
        chk("triv_starts", 64'(start_cnt - base), 64'd0);
`else
        chk("triv_starts", 64'(start_cnt - base), 64'd4);
`endif

        // Reset while waiting on the unit
        lat_cfg = 30;
        push(32'd2, 32'd5);
        push(32'd3, 32'd2);
        push(32'd4, 32'd2);
        for (int i = 0; i < 5; i++) step();
        Rst = 1'b1;
        #1;
        chk("midrst_in_ready_low", 64'(in_ready), 64'd0);
        step();
        Rst = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_pow_start", 64'(pow_start), 64'd0);
        base = start_cnt;
        res_base = res_r.size();
        for (int i = 0; i < 40; i++) step();
        chk("midrst_fifo_flushed", 64'(start_cnt - base), 64'd0);
        chk("midrst_no_result", 64'(res_r.size() - res_base), 64'd0);
        lat_cfg = 2;
        push(32'd6, 32'd2);
        expect_res("midrst_next", 64'd36, 8'd0);

        // Tag wraps 255 -> 0
        do_reset();
        lat_cfg = 1;
        for (int i = 0; i < 257; i++) push(32'd1, 32'd1);
        for (int i = 0; i < 257; i++) expect_res("wrap", 64'd1, 8'(i));
        for (int i = 0; i < 20; i++) step();
        chk("wrap_no_extra", 64'(res_r.size()), 64'(rd));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
